// File: rtl/noc_input_buffer.sv
// NoC router input port: a flit FIFO plus the packet-level controller that
// requests routing for the head packet and streams it to the crossbar.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// S_IDLE         | no packet in progress, waiting for a flit in the FIFO
// S_HEADER       | header at FIFO head, routing request (h) raised
// S_SEND_HDR     | connection granted, forwarding the header flit
// S_SEND_SIZE    | forwarding the size flit, which loads the payload count
// S_SEND_PAYLOAD | forwarding payload flits until the count runs out
module noc_input_buffer #(
  parameter int TAM_FLIT   = 16,
  parameter int TAM_BUFFER = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  input  logic [TAM_FLIT-1:0] data_in,
  output logic                credit_o,
  output logic                h,
  input  logic                ack_h,
  output logic                data_av,
  output logic [TAM_FLIT-1:0] data,
  input  logic                data_ack,
  output logic                sender
);

  localparam int PTR_W = (TAM_BUFFER > 1) ? $clog2(TAM_BUFFER) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0]    OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]    OCC_FULL = OCC_W'(TAM_BUFFER);
  localparam logic [TAM_FLIT-1:0] CNT_ONE  = TAM_FLIT'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SEND_HDR,
    S_SEND_SIZE,
    S_SEND_PAYLOAD
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [TAM_FLIT-1:0] cnt_q, cnt_d;
  logic [TAM_FLIT-1:0] mem_q [TAM_BUFFER];

  logic not_empty;
  logic wr_en;
  logic rd_en;

  // Flow control and handshakes decoded from registered occupancy only, so
  // a same-cycle pop can never open credit for a write while full.
  always_comb begin
    not_empty = (occ_q != '0);
    credit_o  = (occ_q < OCC_FULL);
    wr_en     = rx & credit_o;
    rd_en     = data_av & data_ack;
    data      = mem_q[rd_ptr_q];
  end

  // Flit storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Occupancy next value: a simultaneous push and pop cancel out.
  always_comb begin
    occ_d = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Pointers, occupancy, payload counter and FSM state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Packet controller: next state, payload count and port outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h       = 1'b0;
    sender  = 1'b0;
    data_av = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (not_empty) begin
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        h = 1'b1;
        if (ack_h) begin
          state_d = S_SEND_HDR;
        end
      end
      S_SEND_HDR: begin
        sender  = 1'b1;
        data_av = not_empty;
        if (data_av && data_ack) begin
          state_d = S_SEND_SIZE;
        end
      end
      S_SEND_SIZE: begin
        sender  = 1'b1;
        data_av = not_empty;
        if (data_av && data_ack) begin
          cnt_d   = data;
          state_d = (data == '0) ? S_IDLE : S_SEND_PAYLOAD;
        end
      end
      S_SEND_PAYLOAD: begin
        sender  = 1'b1;
        data_av = not_empty;
        if (data_av && data_ack) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
